bcd_to_unsigned: RTL and testbench
==================================

BCD_TO_UNSIGNED -- requirements
Module: bcd_to_unsigned

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port trigger, input, 1 bit: level start request, sampled only while idle=1.
REQ-004 SHALL have port bcd, input, 32 bits: 8 packed BCD digits, digit 0 in bcd[3:0], digit 7 in bcd[31:28].
REQ-005 SHALL have port idle, output, 1 bit: high when ready to accept trigger.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse when out is updated.
REQ-007 SHALL have port out, output, 32 bits: unsigned binary result, held between conversions.
REQ-008 SHALL have port error, output, 1 bit: invalid-digit flag for the last completed conversion.

Function
REQ-009 SHALL implement FSM with states IDLE and CONVERT; idle=1 exactly in IDLE.
REQ-010 In IDLE with trigger=1, SHALL capture bcd into a 32-bit digit register B, clear a 32-bit result register R, clear a 5-bit counter, and enter CONVERT on the next cycle.
REQ-011 In CONVERT, each cycle SHALL shift {B,R} right by 1 (B[0] into R[31]), then subtract 3 from every 4-bit digit of the shifted B whose value is >= 8.
REQ-012 SHALL perform exactly 32 CONVERT cycles, then return to IDLE; on that transition out <= R and done=1 for the first IDLE cycle.
REQ-013 Latency: trigger sampled at edge N -> idle low for cycles N+1..N+32, out/done valid at cycle N+33.
REQ-014 trigger held high SHALL start back-to-back conversions, with idle high exactly one cycle between them, in which done=1 and the next bcd is captured.
REQ-015 bcd and trigger changes during CONVERT SHALL be ignored; the captured value is converted.
REQ-016 Max valid input 99999999 (0x05F5E0FF) SHALL convert without overflow; out[31:27] SHALL be 0 for all valid inputs.
REQ-017 out and error SHALL change only on the IDLE-entry transition or on reset.

Reset
REQ-018 reset=1 SHALL force IDLE, idle=1, done=0, out=32'h0, error=0, counter=0 on the next edge.
REQ-019 reset during CONVERT SHALL abort the conversion; no done pulse, out stays 32'h0.
REQ-020 reset and trigger high together SHALL give reset priority; no conversion starts.

Configuration
REQ-021 Macro BCD_DIGIT_CHECK_EN defined: at capture, any nibble > 9 SHALL set an internal invalid flag; on completion out <= 32'h0 and error <= 1, with the latency unchanged (32 cycles); valid input gives error <= 0.
REQ-022 Macro BCD_DIGIT_CHECK_EN undefined: error SHALL be tied to 0; invalid nibbles are run through the algorithm unchecked, and the result is deterministic but unspecified.

Verification
REQ-023 bcd=32'h00043981, one-cycle trigger -> after 33 cycles out=32'h0000ABCD, done=1 for 1 cycle, error=0.
REQ-024 bcd=32'h99999999 -> out=32'h05F5E0FF; bcd=32'h00000000 -> out=32'h0; bcd=32'h00065535 -> out=32'h0000FFFF.
REQ-025 trigger held high, bcd changed from 32'h00043707 to 32'h00065535 mid-conversion -> out=32'h0000AABB, then out=32'h0000FFFF; idle high 1 cycle between the two.
REQ-026 reset asserted 10 cycles into a conversion of 32'h00043981 -> idle=1, out=32'h0, no done pulse; a fresh trigger then gives out=32'h0000ABCD.
REQ-027 With BCD_DIGIT_CHECK_EN, bcd=32'h0000000A -> after 33 cycles out=32'h0, error=1; next bcd=32'h00000012 -> out=32'h0000000C, error=0.
REQ-028 Without BCD_DIGIT_CHECK_EN, bcd=32'h0000000A -> error stays 0 and latency is 33 cycles; the bench does not check the value of out.

Source files
------------

// File: rtl/bcd_to_unsigned_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The master drives the start request and the packed BCD word. The slave
// (the converter) returns the idle/done status, the binary result and the
// invalid-digit flag.
interface bcd_to_unsigned_if;
    logic        trigger;  // level start request, honoured only while idle
    logic [31:0] bcd;      // 8 packed BCD digits, digit 0 in bcd[3:0]
    logic        idle;     // converter ready to accept trigger
    logic        done;     // one-cycle pulse when out is updated
    logic [31:0] out;      // unsigned binary result, held between conversions
    logic        error;    // invalid-digit flag of the last completed conversion

    modport master (
        output trigger,
        output bcd,
        input  idle,
        input  done,
        input  out,
        input  error
    );

    modport slave (
        input  trigger,
        input  bcd,
        output idle,
        output done,
        output out,
        output error
    );
endinterface : bcd_to_unsigned_if

// File: rtl/bcd_to_unsigned.sv
// Sequential 8-digit BCD to 32-bit unsigned binary converter.
//
// Uses the reverse double-dabble algorithm. The digit register B and the
// result register R form one 64-bit word {B,R}. Each CONVERT cycle shifts
// that word right by one bit. After the shift, every BCD digit of B that is
// 8 or more has 3 subtracted from it. A digit is 8 or more exactly when its
// top bit is set, so that bit alone makes the decision. After 32 steps R holds
// the binary value. The result is published with a one-cycle done pulse on
// the way back to IDLE.
//
// Optional feature, selected by the macro BCD_DIGIT_CHECK_EN:
//   defined   - each nibble of the captured word is checked for a value > 9.
//               An invalid word still runs the full 32 cycles, then publishes
//               out = 0 with error = 1.
//   undefined - error is tied low and invalid nibbles pass through unchecked.
module bcd_to_unsigned (
    input  logic              clk,
    input  logic              reset,   // synchronous, active-high
    bcd_to_unsigned_if.slave  bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    localparam logic [4:0] LAST_STEP = 5'd31;

    state_e      state_q, state_d;
    logic [31:0] b_q, b_d;        // BCD digit register being drained
    logic [31:0] r_q, r_d;        // binary result being filled from the top
    logic [4:0]  cnt_q, cnt_d;    // CONVERT step counter, 0..31
    logic [31:0] out_q, out_d;    // published result
    logic        done_q, done_d;  // completion pulse
`ifdef BCD_DIGIT_CHECK_EN
    logic        invalid_q, invalid_d;  // captured word had a nibble > 9
    logic        error_q, error_d;      // published invalid flag
`endif

    // Subtract 3 from every digit whose value is 8 or more. Such a digit is at
    // most 15 before the subtraction and at least 5 after it, so no borrow
    // ever crosses into the next digit.
    function automatic logic [31:0] adjust_digits(input logic [31:0] b);
        logic [31:0] res;
        res = b;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i+3]) begin
                res[4*i +: 4] = b[4*i +: 4] - 4'd3;
            end
        end
        return res;
    endfunction

`ifdef BCD_DIGIT_CHECK_EN
    // Returns 1 when any nibble of the word is greater than 9.
    function automatic logic has_bad_digit(input logic [31:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction
`endif

    // FSM state register plus the control registers that reset must clear
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= '0;
            done_q    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            invalid_q <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            done_q    <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
            invalid_q <= invalid_d;
            error_q   <= error_d;
`endif
        end
    end

    // Working datapath registers, always reloaded at capture
    always_ff @(posedge clk) begin
        // NOTE: B and R have no reset. Every conversion loads them at capture
        // before they are read, and they never reach the outputs directly.
        b_q <= b_d;
        r_q <= r_d;
    end

    // Next-state logic: leave IDLE on trigger, leave CONVERT after step 31
    always_comb begin
        // NOTE: each combinational block assigns a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.trigger) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: capture in IDLE, one shift/adjust step per CONVERT cycle
    always_comb begin
        b_d       = b_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        done_d    = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        invalid_d = invalid_q;
        error_d   = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.trigger) begin
                    b_d       = bus.bcd;
                    r_d       = '0;
                    cnt_d     = '0;
`ifdef BCD_DIGIT_CHECK_EN
                    invalid_d = has_bad_digit(bus.bcd);
`endif
                end
            end
            CONVERT: begin
                // The bottom bit of B moves into the top of R. The shifted B
                // is then brought back to valid BCD.
                r_d   = {b_q[0], r_q[31:1]};
                b_d   = adjust_digits({1'b0, b_q[31:1]});
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    done_d  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                    out_d   = invalid_q ? 32'h0 : r_d;
                    error_d = invalid_q;
`else
                    out_d   = r_d;
`endif
                end
            end
            default: ;
        endcase
    end

    // Output logic: idle is decoded from the state, the rest comes from registers
    always_comb begin
        bus.idle  = (state_q == IDLE);
        bus.done  = done_q;
        bus.out   = out_q;
`ifdef BCD_DIGIT_CHECK_EN
        bus.error = error_q;
`else
        bus.error = 1'b0;
`endif
    end

endmodule : bcd_to_unsigned

// File: tb/tb_bcd_to_unsigned.sv
// Self-checking bench for bcd_to_unsigned.
// Expected results come from a decimal reference model: the sum of
// digit * 10^position, computed with plain integer arithmetic.
module tb_bcd_to_unsigned;

    logic clk;
    logic reset;

    bcd_to_unsigned_if bus ();

    bcd_to_unsigned dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the decimal value of the packed digits.
    function automatic logic [31:0] bcd_ref(input logic [31:0] v);
        longint acc;
        longint scale;
        acc   = 0;
        scale = 1;
        for (int i = 0; i < 8; i++) begin
            acc   = acc + longint'(v[4*i +: 4]) * scale;
            scale = scale * 10;
        end
        return acc[31:0];
    endfunction

    // Build a random valid BCD word with 1..8 significant digits.
    function automatic logic [31:0] rand_bcd();
        logic [31:0] v;
        int          ndig;
        v    = '0;
        ndig = $urandom_range(8, 1);
        for (int i = 0; i < ndig; i++) begin
            v[4*i +: 4] = 4'($urandom_range(9, 0));
        end
        return v;
    endfunction

    // Run one conversion from idle: trigger for one edge, then wait for done.
    // With scramble set, bcd and trigger are disturbed during CONVERT. The
    // trigger is released well before the final step.
    task automatic run_conv(input string name, input logic [31:0] v, input logic [31:0] exp_out,
                            input bit check_out, input bit exp_err, input bit scramble);
        int lat;
        bit idle_seen;
        bus.bcd     = v;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        lat         = 0;
        idle_seen   = 1'b0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.idle !== 1'b0) idle_seen = 1'b1;
            if (scramble) begin
                bus.bcd     = $urandom;
                bus.trigger = (lat < 28) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            tick();
            lat++;
        end
        bus.trigger = 1'b0;
        n_cmp++;
        if (lat !== 32) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges, expected 32", name, lat);
        end
        n_cmp++;
        if (idle_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_during_convert: got idle=1, expected 0", name);
        end
        n_cmp++;
        if (bus.idle !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle_at_done: got %b, expected 1", name, bus.idle);
        end
        if (check_out) begin
            n_cmp++;
            if (bus.out !== exp_out) begin
                n_bad++;
                $display("FAIL %s out: bcd=%h got %h, expected %h", name, v, bus.out, exp_out);
            end
        end
        n_cmp++;
        if (bus.error !== exp_err) begin
            n_bad++;
            $display("FAIL %s error: got %b, expected %b", name, bus.error, exp_err);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.idle !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done_pulse: got done=%b idle=%b, expected done=0 idle=1",
                     name, bus.done, bus.idle);
        end
        if (check_out) begin
            n_cmp++;
            if (bus.out !== exp_out) begin
                n_bad++;
                $display("FAIL %s out_hold: got %h, expected %h", name, bus.out, exp_out);
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.trigger = 1'b0;
        bus.bcd     = '0;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.idle !== 1'b1 || bus.done !== 1'b0 || bus.out !== 32'h0 || bus.error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got idle=%b done=%b out=%h error=%b, expected 1 0 0 0",
                     bus.idle, bus.done, bus.out, bus.error);
        end
    endtask

    task automatic test_directed();
        run_conv("abcd",   32'h00043981, 32'h0000ABCD, 1'b1, 1'b0, 1'b0);
        run_conv("max",    32'h99999999, 32'h05F5E0FF, 1'b1, 1'b0, 1'b0);
        run_conv("zero",   32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_conv("ffff",   32'h00065535, 32'h0000FFFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int k = 0; k < 20; k++) begin
            v = rand_bcd();
            run_conv("random", v, bcd_ref(v), 1'b1, 1'b0, (k % 2) == 1);
            n_cmp++;
            if (bus.out[31:27] !== 5'h0) begin
                n_bad++;
                $display("FAIL random_top_bits: got %h, expected 0", bus.out[31:27]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.bcd     = 32'h00043707;
        bus.trigger = 1'b1;
        tick();
        lat = 0;
        repeat (5) begin
            tick();
            lat++;
        end
        bus.bcd = 32'h00065535;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 32 || bus.out !== 32'h0000AABB || bus.idle !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first: got lat=%0d out=%h idle=%b, expected 32 0000aabb 1",
                     lat, bus.out, bus.idle);
        end
        tick();
        bus.trigger = 1'b0;
        n_cmp++;
        if (bus.idle !== 1'b0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: got idle=%b done=%b, expected 0 0", bus.idle, bus.done);
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 32 || bus.out !== 32'h0000FFFF) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d out=%h, expected 32 0000ffff", lat, bus.out);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit done_seen;
        bus.bcd     = 32'h00043981;
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.idle !== 1'b1 || bus.out !== 32'h0 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_state: got idle=%b out=%h done=%b, expected 1 0 0",
                     bus.idle, bus.out, bus.done);
        end
        done_seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done !== 1'b0) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen !== 1'b0 || bus.out !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_no_done: got done_seen=%b out=%h, expected 0 0", done_seen, bus.out);
        end
        run_conv("after_abort", 32'h00043981, 32'h0000ABCD, 1'b1, 1'b0, 1'b0);

        // Reset and trigger together: reset wins, no conversion starts.
        reset       = 1'b1;
        bus.trigger = 1'b1;
        tick();
        reset       = 1'b0;
        bus.trigger = 1'b0;
        n_cmp++;
        if (bus.idle !== 1'b1 || bus.out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_priority: got idle=%b out=%h, expected 1 0", bus.idle, bus.out);
        end
        tick();
        n_cmp++;
        if (bus.idle !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_priority_hold: got idle=%b done=%b, expected 1 0", bus.idle, bus.done);
        end
    endtask

    task automatic test_invalid_digit();
`ifdef BCD_DIGIT_CHECK_EN
        run_conv("invalid", 32'h0000000A, 32'h0, 1'b1, 1'b1, 1'b0);
        run_conv("valid_after_invalid", 32'h00000012, 32'h0000000C, 1'b1, 1'b0, 1'b0);
`else
        run_conv("invalid_nocheck", 32'h0000000A, 32'h0, 1'b0, 1'b0, 1'b0);
        run_conv("valid_after_invalid", 32'h00000012, 32'h0000000C, 1'b1, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        reset       = 1'b1;
        bus.trigger = 1'b0;
        bus.bcd     = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_invalid_digit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bcd_to_unsigned
